// File: rtl/givens_pkg.sv
// Shared constants, state encoding and fixed-point helpers
// for the Givens rotation unit.
package givens_pkg;

   localparam int DATA_W   = 32;
   localparam int FRAC_W   = 16;
   localparam int ADDR_W   = 2;
   localparam int BRAM_LAT = 2;
   localparam int PROD_W   = 2 * DATA_W;
   localparam int SUM_W    = 2 * DATA_W + 1;

   localparam logic [ADDR_W-1:0] G00_ADDR = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] G01_ADDR = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] G10_ADDR = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] G11_ADDR = ADDR_W'(3);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      RUN
   } state_t;

   // Floor shift by FRAC_W, then clamp to the DATA_W signed range.
   function automatic logic signed [DATA_W-1:0] sat_shift(
      input logic signed [SUM_W-1:0] s
   );
      logic signed [SUM_W-1:0] sh;
      logic signed [SUM_W-1:0] hi;
      logic signed [SUM_W-1:0] lo;
      sh = s >>> FRAC_W;
      hi = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
      lo = ~hi;
      if (sh > hi)
         return {1'b0, {(DATA_W-1){1'b1}}};
      else if (sh < lo)
         return {1'b1, {(DATA_W-1){1'b0}}};
      else
         return sh[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/givens_mac_lane.sv
// One output lane: q = sat((a*x + b*y) >>> FRAC_W),
// two register stages sharing one advance enable.
module givens_mac_lane
   import givens_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] coef_a,
   input  logic [DATA_W-1:0] coef_b,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   output logic [DATA_W-1:0] q
);

   logic signed [PROD_W-1:0] prod_a;
   logic signed [PROD_W-1:0] prod_b;
   logic signed [SUM_W-1:0]  sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_a <= '0;
         prod_b <= '0;
      end else if (en) begin
         prod_a <= PROD_W'($signed(coef_a)) * PROD_W'($signed(x));
         prod_b <= PROD_W'($signed(coef_b)) * PROD_W'($signed(y));
      end
   end

   assign sum = SUM_W'(prod_a) + SUM_W'(prod_b);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= sat_shift(sum);
   end

endmodule

// File: rtl/givens_rotation_unit.sv
// Fetches a 2x2 rotation matrix from BRAM port B and streams
// rotated (x, y) pairs through a two-stage MAC pipeline.
module givens_rotation_unit
   import givens_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   output logic              ena_rotation,
   output logic              wea_rotation,
   output logic [ADDR_W-1:0] addra_rotation,
   output logic [DATA_W-1:0] dina_rotation,
   input  logic [DATA_W-1:0] douta_rotation,
   output logic              coef_ready,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_x,
   output logic [DATA_W-1:0] out_y
);

   state_t state;
   state_t state_nx;

   logic [ADDR_W-1:0]   cnt;
   logic                pending;
   logic [BRAM_LAT-1:0] vpipe;
   logic [ADDR_W-1:0]   apipe [BRAM_LAT];
   logic                cap_v;
   logic [ADDR_W-1:0]   cap_a;
   logic [DATA_W-1:0]   coef  [4];
   logic                adv;
   logic                accept;
   logic                v1;
   logic                empty;

   assign wea_rotation  = 1'b0;
   assign dina_rotation = '0;

   assign cap_v  = vpipe[BRAM_LAT-1];
   assign cap_a  = apipe[BRAM_LAT-1];
   assign adv    = !out_valid || out_ready;
   assign empty  = !v1 && !out_valid;
   assign in_ready = coef_ready && !pending && adv;
   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (load_start) state_nx = FETCH;
         FETCH: if (cnt == G11_ADDR) state_nx = DRAIN;
         DRAIN: if (cap_v && cap_a == G11_ADDR) state_nx = RUN;
         RUN:   if (pending && empty) state_nx = FETCH;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ena_rotation   = 1'b0;
      addra_rotation = '0;
      coef_ready     = 1'b0;
      unique case (state)
         FETCH: begin
            ena_rotation   = 1'b1;
            addra_rotation = cnt;
         end
         RUN:     coef_ready = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (state == FETCH)
         cnt <= cnt + 1'b1;
      else
         cnt <= '0;
   end

   // Pending survives until the FSM actually leaves RUN.
   always_ff @(posedge clk) begin
      if (rst)
         pending <= 1'b0;
      else if (state != RUN)
         pending <= 1'b0;
      else if (load_start)
         pending <= 1'b1;
   end

   // Issue enable/address delayed to line up with read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         vpipe <= '0;
         for (int i = 0; i < BRAM_LAT; i++)
            apipe[i] <= '0;
      end else begin
         vpipe[0] <= ena_rotation;
         apipe[0] <= addra_rotation;
         for (int i = 1; i < BRAM_LAT; i++) begin
            vpipe[i] <= vpipe[i-1];
            apipe[i] <= apipe[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++)
            coef[i] <= '0;
      end else if (cap_v) begin
         coef[cap_a] <= douta_rotation;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         out_valid <= 1'b0;
      end else if (adv) begin
         v1        <= accept;
         out_valid <= v1;
      end
   end

   givens_mac_lane u_lane_x (
      .clk    (clk),
      .rst    (rst),
      .en     (adv),
      .coef_a (coef[G00_ADDR]),
      .coef_b (coef[G01_ADDR]),
      .x      (in_x),
      .y      (in_y),
      .q      (out_x)
   );

   givens_mac_lane u_lane_y (
      .clk    (clk),
      .rst    (rst),
      .en     (adv),
      .coef_a (coef[G10_ADDR]),
      .coef_b (coef[G11_ADDR]),
      .x      (in_x),
      .y      (in_y),
      .q      (out_y)
   );

endmodule

// File: doc/givens_rotation_unit.md
# givens_rotation_unit

Downstream consumer of the Givens-matrix dual-port BRAM. It fetches the four 2×2 rotation coefficients through the BRAM's rotation port (port B, 2-cycle read latency) and applies the rotation to a stream of signed fixed-point (x, y) pairs. Output is x' = G00·x + G01·y and y' = G10·x + G11·y, delivered over valid/ready handshakes to the covariance-update stage of the PCA datapath.

## Interface
- DATA_W, 32: sample and coefficient width, signed two's complement
- FRAC_W, 16: fractional bits (Q16.16)
- ADDR_W, 2: BRAM address width
- BRAM_LAT, 2: BRAM read latency in cycles
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous active-high reset
- load_start  in  1  single-cycle pulse requesting a (re)fetch of the coefficients
- ena_rotation  out  1  BRAM port-B enable
- wea_rotation  out  1  BRAM port-B write enable, constant 0
- addra_rotation  out  ADDR_W  BRAM port-B address
- dina_rotation  out  DATA_W  constant 0
- douta_rotation  in  DATA_W  BRAM port-B read data
- coef_ready  out  1  coefficients valid, unit accepting samples
- in_valid / in_ready  in / out  1  input handshake
- in_x, in_y  in  DATA_W  input pair
- out_valid / out_ready  out / in  1  output handshake
- out_x, out_y  out  DATA_W  rotated pair

## Operation
- Coefficient layout is row-major:
  - addr 0 = G00 (c)
  - addr 1 = G01 (−s)
  - addr 2 = G10 (s)
  - addr 3 = G11 (c)
- FSM states:
  - IDLE → FETCH on load_start.
  - FETCH: issue addresses 0,1,2,3 on consecutive cycles with ena_rotation=1. The word for the address issued in cycle k is captured in cycle k+BRAM_LAT. After the fourth issue, go to DRAIN.
  - DRAIN: ena_rotation=0. Wait until the last capture, then go to RUN.
  - RUN: coef_ready=1. On load_start, set a pending flag. Once the pending flag is set and the pipeline is empty (no in-flight or un-taken outputs), go to FETCH and clear coef_ready.
- in_ready = (state==RUN) && !pending && (!out_valid || out_ready).
- load_start in FETCH or DRAIN is ignored.
- The pipeline has two stages and a single global advance enable = !out_valid || out_ready:
  - Stage 1 registers four products, each 2·DATA_W signed.
  - Stage 2 forms two (2·DATA_W+1)-bit sums, shifts right arithmetically by FRAC_W (floor), saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1], and registers the result into out_x/out_y.
- Coefficients change only in FETCH. Samples already in flight always complete with the old coefficients.
- Reset value of every output is 0, including coef_ready, in_ready, out_valid, ena_rotation, addra_rotation, out_x and out_y. State returns to IDLE, the pending flag clears and the coefficient registers clear.
- Reset mid-FETCH aborts the fetch. Reset mid-stream discards all in-flight samples.

## Timing
- load_start accepted in cycle t:
  - addresses 0..3 are driven in cycles t+1..t+4
  - captures occur in cycles t+3..t+6
  - coef_ready=1 from cycle t+7
- Sample accepted in cycle t (in_valid && in_ready) → out_valid=1 in cycle t+2, provided there is no stall.
- Throughput is one pair per cycle.
- out_x/out_y are held stable while out_valid && !out_ready.

## Structure
- Shared package givens_pkg holds:
  - DATA_W, FRAC_W, BRAM_LAT
  - coefficient address constants G00_ADDR..G11_ADDR
  - the state enum (IDLE, FETCH, DRAIN, RUN)
  - a sat_shift function performing the shift and saturation
- Sub-module givens_mac_lane computes one output lane (two products, sum, shift, saturate, two register stages). It is instantiated twice, once for x' and once for y'.
- The top level holds the FSM, the fetch address counter, the capture shift/valid pipe matched to BRAM_LAT, and the handshake logic.

## Test plan
- Identity load (0x00010000, 0, 0, 0x00010000), then x=0x00050000, y=0xFFFD0000 → out_x=0x00050000, out_y=0xFFFD0000 exactly 2 cycles after acceptance; coef_ready rises at t+7.
- 90° matrix (0, 0xFFFF0000, 0x00010000, 0), x=0x00020000, y=0x00010000 → out_x=0xFFFF0000, out_y=0x00020000.
- Saturation: G00=G01=0x00020000, x=y=0x40000000 → out_x=0x7FFFFFFF. With x=y=0xC0000000 → out_x=0x80000000.
- Backpressure: 8-pair back-to-back stream with out_ready low for 5 cycles mid-stream → in_ready low during the stall, no loss or duplication, order preserved, outputs held stable.
- load_start mid-stream → in_ready drops, in-flight pairs exit rotated by the old matrix, addra_rotation sequences 0,1,2,3, and subsequent pairs use the new matrix.
- rst asserted in the second FETCH cycle → all outputs 0 in the following cycle. A later load_start performs a complete fresh fetch.
